// File: rtl/arm_cpu_pkg.sv
// Shared constants for the arm_cpu ARM-subset core: memory geometry,
// instruction field positions, condition codes, ALU opcodes, flag indices.
package arm_cpu_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned IMEM_WORDS = 64;
  localparam int unsigned DMEM_WORDS = 64;
  localparam int unsigned IMEM_AW    = $clog2(IMEM_WORDS);
  localparam int unsigned DMEM_AW    = $clog2(DMEM_WORDS);
  localparam int unsigned NUM_GPR    = 15;

  localparam logic [3:0] REG_LR = 4'd14;
  localparam logic [3:0] REG_PC = 4'd15;

  // Instruction field positions
  localparam int unsigned COND_LSB = 28;
  localparam int unsigned I_BIT    = 25;
  localparam int unsigned BL_BIT   = 24;
  localparam int unsigned U_BIT    = 23;
  localparam int unsigned OPC_LSB  = 21;
  localparam int unsigned S_BIT    = 20;
  localparam int unsigned L_BIT    = 20;
  localparam int unsigned RN_LSB   = 16;
  localparam int unsigned RD_LSB   = 12;
  localparam int unsigned RS_LSB   = 8;
  localparam int unsigned RM_LSB   = 0;

  // Instruction class encodings
  localparam logic [1:0]  CLASS_DP   = 2'b00;
  localparam logic [1:0]  CLASS_MEM  = 2'b01;
  localparam logic [2:0]  CLASS_BR   = 3'b101;
  localparam logic [5:0]  MUL_HI     = 6'b000000;
  localparam logic [3:0]  MUL_LO     = 4'b1001;
  localparam logic [23:0] HALT_IMM24 = 24'hFFFFFE;

  // Condition codes
  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;

  // Data-processing opcodes
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_RSB = 4'b0011;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  // Bit positions within the {N,Z,C,V} flag nibble
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // Evaluate a condition field against the current flags
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    n = f[FLAG_N];
    z = f[FLAG_Z];
    c = f[FLAG_C];
    v = f[FLAG_V];
    case (cond)
      COND_EQ: cond_pass = z;
      COND_NE: cond_pass = !z;
      COND_CS: cond_pass = c;
      COND_CC: cond_pass = !c;
      COND_MI: cond_pass = n;
      COND_PL: cond_pass = !n;
      COND_VS: cond_pass = v;
      COND_VC: cond_pass = !v;
      COND_HI: cond_pass = c && !z;
      COND_LS: cond_pass = !c || z;
      COND_GE: cond_pass = (n == v);
      COND_LT: cond_pass = (n != v);
      COND_GT: cond_pass = !z && (n == v);
      COND_LE: cond_pass = z || (n != v);
      COND_AL: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  // Immediate operand: imm8 rotated right by twice the 4-bit rotate field
  function automatic logic [31:0] rot_imm(input logic [7:0] imm8, input logic [3:0] rot);
    logic [63:0] dbl;
    dbl = {24'd0, imm8, 24'd0, imm8} >> {rot, 1'b0};
    rot_imm = dbl[31:0];
  endfunction

endpackage

// File: rtl/arm_cpu_alu.sv
// Combinational data-processing ALU: result plus updated {N,Z,C,V}.
// Logical ops pass carry/overflow through unchanged.
module arm_cpu_alu
  import arm_cpu_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        c_i,
  input  logic        v_i,
  output logic [31:0] res_o,
  output logic [3:0]  nzcv_o
);

  logic [31:0] x, y, res;
  logic        cin, arith;
  logic [32:0] sum;

  // Select adder operands or logical result per opcode
  always_comb begin
    x     = a_i;
    y     = b_i;
    cin   = 1'b0;
    arith = 1'b0;
    res   = '0;
    case (op_i)
      OP_AND: res = a_i & b_i;
      OP_EOR: res = a_i ^ b_i;
      OP_ORR: res = a_i | b_i;
      OP_MOV: res = b_i;
      OP_MVN: res = ~b_i;
      OP_ADD: arith = 1'b1;
      OP_SUB, OP_CMP: begin
        arith = 1'b1;
        y     = ~b_i;
        cin   = 1'b1;
      end
      OP_RSB: begin
        arith = 1'b1;
        x     = b_i;
        y     = ~a_i;
        cin   = 1'b1;
      end
      default: res = '0;
    endcase
    sum = {1'b0, x} + {1'b0, y} + 33'(cin);
    if (arith) res = sum[31:0];
  end

  // Flags: carry is adder carry-out (NOT borrow for subtracts)
  always_comb begin
    nzcv_o         = '0;
    nzcv_o[FLAG_N] = res[31];
    nzcv_o[FLAG_Z] = (res == '0);
    nzcv_o[FLAG_C] = arith ? sum[32] : c_i;
    nzcv_o[FLAG_V] = arith ? ((x[31] == y[31]) && (res[31] != x[31])) : v_i;
  end

  assign res_o = res;

endmodule

// File: rtl/arm_cpu.sv
// Single-cycle ARM-subset core with internal instruction/data memories.
// Define CPU_MUL_EN to add the MUL instruction; otherwise it decodes as a NOP.
module arm_cpu
  import arm_cpu_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        imem_we_in,
  input  logic [5:0]  imem_addr_in,
  input  logic [31:0] imem_wdata_in,
  input  logic [3:0]  dbg_sel_in,
  output logic [31:0] dbg_data_out,
  output logic [31:0] pc_out,
  output logic [3:0]  flags_out,
  output logic        halted_out
);

  logic [31:0] pc_q, pc_d;
  logic [3:0]  flags_q, flags_d;
  logic        halted_q, halted_d;
  logic [31:0] rf_q   [NUM_GPR];
  logic [31:0] imem_q [IMEM_WORDS];
  logic [31:0] dmem_q [DMEM_WORDS];

  logic [31:0] instr, pc_plus4, pc_plus8;
  logic [3:0]  rn, rd, rm, opc;
  logic [31:0] rn_val, rm_val, rd_val, op2;
  logic        cond_ok, is_mul, is_dp, is_mem, is_br;
  logic        dp_known, dp_writes, dp_flags;
  logic [31:0] alu_res;
  logic [3:0]  alu_nzcv;
  logic [31:0] mem_addr, ld_data, br_target;
  logic        unused_addr_bits;
  logic        wr_en, st_en;
  logic [3:0]  wr_idx;
  logic [31:0] wr_data;

  assign instr    = imem_q[pc_q[IMEM_AW+1:2]];
  assign pc_plus4 = pc_q + 32'd4;
  assign pc_plus8 = pc_q + 32'd8;

  assign rn  = instr[RN_LSB +: 4];
  assign rd  = instr[RD_LSB +: 4];
  assign rm  = instr[RM_LSB +: 4];
  assign opc = instr[OPC_LSB +: 4];

  // Register reads; R15 as an operand sees PC+8
  assign rn_val = (rn == REG_PC) ? pc_plus8 : rf_q[rn];
  assign rm_val = (rm == REG_PC) ? pc_plus8 : rf_q[rm];
  assign rd_val = (rd == REG_PC) ? pc_plus8 : rf_q[rd];
  assign dbg_data_out = (dbg_sel_in == REG_PC) ? pc_q : rf_q[dbg_sel_in];

  // Instruction class decode
  assign cond_ok = cond_pass(instr[COND_LSB +: 4], flags_q);
  assign is_mul  = (instr[27:22] == MUL_HI) && (instr[7:4] == MUL_LO);
  assign is_dp   = (instr[27:26] == CLASS_DP) && !is_mul;
  assign is_mem  = (instr[27:26] == CLASS_MEM) && !instr[I_BIT];
  assign is_br   = (instr[27:25] == CLASS_BR);

  assign dp_known  = (opc == OP_AND) || (opc == OP_EOR) || (opc == OP_SUB) ||
                     (opc == OP_RSB) || (opc == OP_ADD) || (opc == OP_CMP) ||
                     (opc == OP_ORR) || (opc == OP_MOV) || (opc == OP_MVN);
  assign dp_writes = dp_known && (opc != OP_CMP);
  assign dp_flags  = dp_known && (instr[S_BIT] || (opc == OP_CMP));

  assign op2 = instr[I_BIT] ? rot_imm(instr[7:0], instr[11:8]) : rm_val;

  arm_cpu_alu u_alu (
    .op_i   (opc),
    .a_i    (rn_val),
    .b_i    (op2),
    .c_i    (flags_q[FLAG_C]),
    .v_i    (flags_q[FLAG_V]),
    .res_o  (alu_res),
    .nzcv_o (alu_nzcv)
  );

  // Offset addressing, word granularity
  assign mem_addr = instr[U_BIT] ? (rn_val + 32'(instr[11:0])) : (rn_val - 32'(instr[11:0]));
  assign ld_data  = dmem_q[mem_addr[DMEM_AW+1:2]];
  assign unused_addr_bits = ^{mem_addr[31:DMEM_AW+2], mem_addr[1:0]};

  assign br_target = pc_plus8 + {{6{instr[23]}}, instr[23:0], 2'b00};

`ifdef CPU_MUL_EN
  logic [3:0]  rs;
  logic [31:0] rs_val, mul_res;
  assign rs      = instr[RS_LSB +: 4];
  assign rs_val  = (rs == REG_PC) ? pc_plus8 : rf_q[rs];
  assign mul_res = rm_val * rs_val;
`endif

  // Next-state: PC, flags, halt, register write and store strobe
  always_comb begin
    pc_d     = pc_plus4;
    flags_d  = flags_q;
    halted_d = halted_q;
    wr_en    = 1'b0;
    wr_idx   = rd;
    wr_data  = alu_res;
    st_en    = 1'b0;
    if (cond_ok) begin
      if (is_dp) begin
        wr_en = dp_writes;
        if (dp_flags) flags_d = alu_nzcv;
      end else if (is_mem) begin
        if (instr[L_BIT]) begin
          wr_en   = 1'b1;
          wr_data = ld_data;
        end else begin
          st_en = 1'b1;
        end
      end else if (is_br) begin
        pc_d = br_target;
        if (instr[BL_BIT]) begin
          wr_en   = 1'b1;
          wr_idx  = REG_LR;
          wr_data = pc_plus4;
        end
        if (instr[23:0] == HALT_IMM24) halted_d = 1'b1;
      end
`ifdef CPU_MUL_EN
      else if (is_mul) begin
        wr_en   = 1'b1;
        wr_idx  = rn;
        wr_data = mul_res;
        if (instr[S_BIT]) begin
          flags_d[FLAG_N] = mul_res[31];
          flags_d[FLAG_Z] = (mul_res == '0);
        end
      end
`endif
    end
    if (wr_en && (wr_idx == REG_PC)) pc_d = wr_data;
  end

  // Architectural state with async reset
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pc_q     <= '0;
      flags_q  <= '0;
      halted_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_GPR; i++) rf_q[i] <= '0;
    end else begin
      pc_q     <= pc_d;
      flags_q  <= flags_d;
      halted_q <= halted_d;
      if (wr_en && (wr_idx != REG_PC)) rf_q[wr_idx] <= wr_data;
    end
  end

  // Instruction memory is loadable only while the core is held in reset
  always_ff @(posedge clk_in) begin
    if (!rst_n_in && imem_we_in) imem_q[imem_addr_in] <= imem_wdata_in;
  end

  // Data memory store port; contents survive reset
  always_ff @(posedge clk_in) begin
    if (rst_n_in && st_en) dmem_q[mem_addr[DMEM_AW+1:2]] <= rd_val;
  end

  assign pc_out     = pc_q;
  assign flags_out  = flags_q;
  assign halted_out = halted_q;

endmodule

// File: tb/tb_arm_cpu.sv
// Scoreboard bench for arm_cpu: each directed program ends in a branch-to-self;
// expectations are queued and a monitor checks them once the core halts
// (or while it is held in reset).
`timescale 1ns/1ps
module tb_arm_cpu;

  localparam logic [31:0] HALT = 32'hEAFFFFFE;
  localparam int K_REG   = 0;
  localparam int K_PC    = 1;
  localparam int K_FLAGS = 2;
  localparam int K_HALT  = 3;

  typedef struct {
    string       name;
    int          kind;
    logic [3:0]  sel;
    logic [31:0] val;
  } exp_t;

  logic        clk_in, rst_n_in, imem_we_in, halted_out;
  logic [5:0]  imem_addr_in;
  logic [31:0] imem_wdata_in, dbg_data_out, pc_out;
  logic [3:0]  dbg_sel_in, flags_out;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] prog [64];
  int          prog_len = 0;

  exp_t        m_item;
  logic [31:0] m_act;

  arm_cpu dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .imem_we_in    (imem_we_in),
    .imem_addr_in  (imem_addr_in),
    .imem_wdata_in (imem_wdata_in),
    .dbg_sel_in    (dbg_sel_in),
    .dbg_data_out  (dbg_data_out),
    .pc_out        (pc_out),
    .flags_out     (flags_out),
    .halted_out    (halted_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic push(input string nm, input int k, input logic [3:0] s, input logic [31:0] v);
    exp_t e;
    e.name = nm;
    e.kind = k;
    e.sel  = s;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic put(input logic [31:0] w);
    prog[prog_len] = w;
    prog_len++;
  endtask

  // Hold reset, write the whole imem (unused words = B .), then release
  task automatic load_prog();
    @(negedge clk_in);
    rst_n_in = 1'b0;
    for (int i = 0; i < 64; i++) begin
      imem_we_in    = 1'b1;
      imem_addr_in  = 6'(i);
      imem_wdata_in = (i < prog_len) ? prog[i] : HALT;
      @(negedge clk_in);
    end
    imem_we_in = 1'b0;
    rst_n_in   = 1'b1;
    prog_len   = 0;
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk_in);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: %0d expectations still pending, halted=%0b pc=0x%08h",
               nm, exp_q.size(), halted_out, pc_out);
      exp_q.delete();
    end
  endtask

  // Monitor: one expectation per falling edge once the core is stable
  initial begin
    dbg_sel_in = 4'd0;
    forever begin
      @(negedge clk_in);
      if (exp_q.size() != 0 && (halted_out || !rst_n_in)) begin
        m_item = exp_q.pop_front();
        case (m_item.kind)
          K_REG: begin
            dbg_sel_in = m_item.sel;
            #1;
            m_act = dbg_data_out;
          end
          K_PC:    m_act = pc_out;
          K_FLAGS: m_act = {28'd0, flags_out};
          default: m_act = {31'd0, halted_out};
        endcase
        checks++;
        if (m_act !== m_item.val) begin
          errors++;
          $display("FAIL %s: got 0x%08h expected 0x%08h", m_item.name, m_act, m_item.val);
        end
      end
    end
  end

  initial begin
    rst_n_in      = 1'b0;
    imem_we_in    = 1'b0;
    imem_addr_in  = '0;
    imem_wdata_in = '0;

    // Reset state
    push("rst_pc", K_PC, 0, 32'h0);
    push("rst_halt", K_HALT, 0, 32'h0);
    push("rst_flags", K_FLAGS, 0, 32'h0);
    push("rst_r1", K_REG, 1, 32'h0);
    wait_drain("reset");

    // Reset/load: MOV R1,#5 then halt at 4
    put(32'hE3A01005);
    put(HALT);
    load_prog();
    push("load_r1", K_REG, 1, 32'd5);
    push("load_pc", K_PC, 0, 32'd4);
    push("load_halt", K_HALT, 0, 32'd1);
    wait_drain("load");

    // SUBS to zero: Z and C set
    put(32'hE3A01005);
    put(32'hE3A02005);
    put(32'hE0513002);
    put(HALT);
    load_prog();
    push("subs_r3", K_REG, 3, 32'h0);
    push("subs_flags", K_FLAGS, 0, 32'h6);
    push("subs_r2", K_REG, 2, 32'd5);
    wait_drain("subs");

    // Rotated immediate and signed overflow
    put(32'hE3A0047F);
    put(32'hE0900000);
    put(HALT);
    load_prog();
    push("ovf_r0", K_REG, 0, 32'hFE000000);
    push("ovf_flags", K_FLAGS, 0, 32'h9);
    wait_drain("ovf");

    // Store/load, positive and negative offsets
    put(32'hE3A040AB);
    put(32'hE3A05010);
    put(32'hE5854004);
    put(32'hE5956004);
    put(32'hE3A0B018);
    put(32'hE51BA004);
    put(HALT);
    load_prog();
    push("ldr_r6", K_REG, 6, 32'hAB);
    push("ldr_neg_r10", K_REG, 10, 32'hAB);
    push("mem_r5", K_REG, 5, 32'h10);
    wait_drain("mem");

    // Data memory survives reset
    put(32'hE5906014);
    put(HALT);
    load_prog();
    push("dmem_keep_r6", K_REG, 6, 32'hAB);
    push("dmem_keep_pc", K_PC, 0, 32'd4);
    wait_drain("dmem_keep");

    // Logical ops, RSB, flag preservation, BL and R15 reads
    put(32'hE3A010F0);  // 00 MOV R1,#0xF0
    put(32'hE3A0203C);  // 04 MOV R2,#0x3C
    put(32'hE0013002);  // 08 AND R3,R1,R2
    put(32'hE0214002);  // 0C EOR R4,R1,R2
    put(32'hE1815002);  // 10 ORR R5,R1,R2
    put(32'hE1E06002);  // 14 MVN R6,R2
    put(32'hE0617002);  // 18 RSB R7,R1,R2
    put(32'hE0519002);  // 1C SUBS R9,R1,R2
    put(32'hE0318001);  // 20 EORS R8,R1,R1
    put(32'hEB000001);  // 24 BL 0x30
    put(HALT);          // 28 B .
    put(HALT);          // 2C
    put(32'hE1A0A00F);  // 30 MOV R10,R15
    put(32'hE1A0F00E);  // 34 MOV R15,R14
    load_prog();
    push("and_r3", K_REG, 3, 32'h30);
    push("eor_r4", K_REG, 4, 32'hCC);
    push("orr_r5", K_REG, 5, 32'hFC);
    push("mvn_r6", K_REG, 6, 32'hFFFFFFC3);
    push("rsb_r7", K_REG, 7, 32'hFFFFFF4C);
    push("sub_r9", K_REG, 9, 32'hB4);
    push("eors_r8", K_REG, 8, 32'h0);
    push("logic_flags", K_FLAGS, 0, 32'h6);
    push("bl_r14", K_REG, 14, 32'h28);
    push("r15_read_r10", K_REG, 10, 32'h38);
    push("ret_pc", K_PC, 0, 32'h28);
    push("dbg_r15", K_REG, 15, 32'h28);
    wait_drain("logic");

    // Conditional execution and branch, halt at 0x20
    put(32'hE3A01003);  // 00 MOV R1,#3
    put(32'hE1510001);  // 04 CMP R1,R1
    put(32'h1A000000);  // 08 BNE 0x10 (not taken)
    put(32'hE3A07001);  // 0C MOV R7,#1
    put(32'h0A000000);  // 10 BEQ 0x18
    put(32'hE3A08001);  // 14 MOV R8,#1 (skipped)
    put(32'hE3A09002);  // 18 MOV R9,#2
    put(32'h13A0C009);  // 1C MOVNE R12,#9 (fails)
    put(HALT);          // 20 B .
    load_prog();
    push("bne_r7", K_REG, 7, 32'd1);
    push("beq_r8", K_REG, 8, 32'd0);
    push("beq_r9", K_REG, 9, 32'd2);
    push("movne_r12", K_REG, 12, 32'd0);
    push("cmp_flags", K_FLAGS, 0, 32'h6);
    push("halt_pc", K_PC, 0, 32'h20);
    push("halt_flag", K_HALT, 0, 32'd1);
    push("halt_pc_hold", K_PC, 0, 32'h20);
    wait_drain("cond");

    // Mid-cycle reset clears PC/halt at once; imem is kept for the rerun
    @(posedge clk_in);
    #2;
    rst_n_in = 1'b0;
    push("midrst_pc", K_PC, 0, 32'h0);
    push("midrst_halt", K_HALT, 0, 32'h0);
    push("midrst_flags", K_FLAGS, 0, 32'h0);
    push("midrst_r7", K_REG, 7, 32'h0);
    wait_drain("midrst");
    @(negedge clk_in);
    rst_n_in = 1'b1;
    push("rerun_r7", K_REG, 7, 32'd1);
    push("rerun_r9", K_REG, 9, 32'd2);
    push("rerun_pc", K_PC, 0, 32'h20);
    wait_drain("rerun");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/arm_cpu.md
Name: arm_cpu

Overview:
- Single-cycle, 32-bit, ARM-subset processor.
- Contains its own instruction memory (loaded by the bench while in reset), register file, ALU, NZCV flags and word-addressed data memory.
- Top-level compute block of the design; driven only by clock and reset, with a debug port for observation.

Parameters:
- IMEM_WORDS, 64, instruction memory depth in 32-bit words; PC index = pc[7:2], wraps modulo depth.
- DMEM_WORDS, 64, data memory depth in 32-bit words; address index = addr[7:2], wraps modulo depth.

Ports:
- clk_in, input, 1, system clock; all state updates on the rising edge.
- rst_n_in, input, 1, asynchronous active-low reset.
- imem_we_in, input, 1, instruction-memory write strobe; honoured only while rst_n_in=0.
- imem_addr_in, input, 6, instruction word index to write.
- imem_wdata_in, input, 32, instruction word to write.
- dbg_sel_in, input, 4, register-file index for debug read.
- dbg_data_out, output, 32, combinational value of R[dbg_sel_in]; R15 reads as the current PC.
- pc_out, output, 32, current PC.
- flags_out, output, 4, {N,Z,C,V}.
- halted_out, output, 1, high once a branch-to-self executes.

Behaviour:
- Reset (async assert, sync use at the next edge after release):
  - PC=0, R0-R14=0, NZCV=0, halted_out=0.
  - Data memory is not cleared.
  - Instruction memory retains contents; writes via imem_we_in occur on clk_in edges while in reset.
- Execution: one instruction per cycle, fetched from imem[pc[7:2]].
  - PC advances +4 unless branching.
  - Reads of R15 as an operand return PC+8.
- Condition field [31:28]: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL per ARM.
  - A failed condition acts as a NOP (PC+4, no state change).
- Data processing (bits[27:26]=00):
  - I bit[25]: operand2 = imm8 rotated right by 2*rot4; otherwise Rm with no shift (shift field ignored).
  - Opcodes: AND 0000, EOR 0001, SUB 0010, RSB 0011, ADD 0100, CMP 1010, ORR 1100, MOV 1101, MVN 1111. Other opcodes are NOPs.
  - S bit updates NZCV: N=res[31], Z=(res==0).
  - C for ADD: carry out. C for SUB/RSB/CMP: NOT borrow.
  - V: signed overflow for arithmetic ops only; logical ops leave C and V unchanged.
  - CMP always sets flags and never writes Rd.
  - Rd=15 writes go to PC (a branch).
- Memory (bits[27:26]=01), LDR L=1 / STR L=0:
  - Address = Rn ± imm12, with U bit[23] selecting +/−. Offset addressing only; no writeback.
  - Word-aligned; low 2 address bits ignored.
  - STR writes on the clock edge. LDR data is combinational and written to Rd on the same edge.
- Branch (bits[27:25]=101):
  - PC = PC+8+(signext(imm24)<<2).
  - L bit: BL additionally writes R14 = PC+4.
  - Branch with imm24 = 0xFFFFFE (target = own PC) sets halted_out=1 (sticky until reset). The PC keeps re-executing that instruction.
- Unsupported encodings (incl. bits[27:26]=11) execute as NOPs.
- Arithmetic is modulo 2^32; no exceptions.

Optional Feature:
- CPU_MUL_EN defined: MUL (bits[27:22]=000000, bits[7:4]=1001) computes Rd[19:16] = low 32 bits of Rm*Rs. The S bit updates N and Z only.
- CPU_MUL_EN undefined: that encoding is a NOP, and no multiplier is synthesised.

Decomposition:
- Shared package arm_cpu_pkg: condition-code constants, data-processing opcode constants, instruction-class field positions, and flag bit indices.
- One natural sub-module, arm_cpu_alu: combinational; opcode, A, B and carry in → result and NZCV out.
- Register file, memories and control stay in arm_cpu.

Test Plan:
- Reset/load:
  - Hold rst_n_in=0 and load MOV R1,#5 (0xE3A01005).
  - Release reset.
  - After 1 clock: dbg_sel_in=1 → 5, pc_out=4.
- Arithmetic/flags:
  - Sequence: MOV R1,#5; MOV R2,#5; SUBS R3,R1,R2.
  - Required: R3=0, flags_out=0110 (Z=1, C=1).
- Rotated immediate and overflow:
  - MOV R0,#0x7F000000 (imm8=0x7F, rot=4); ADDS R0,R0,R0.
  - Required: R0=0xFE000000, N=1, V=1, C=0.
- Memory:
  - MOV R4,#0xAB; MOV R5,#0x10; STR R4,[R5,#4]; LDR R6,[R5,#4].
  - Required: R6=0xAB.
- Conditional branch:
  - CMP R1,R1; BNE skip; MOV R7,#1.
  - Required: R7=1, and the BNE does not alter the PC.
  - Then BEQ +1 word skips the next MOV.
- Halt and reset mid-run:
  - B . at address 0x20 → halted_out=1, pc_out stays 0x20.
  - Pulse rst_n_in low mid-cycle → pc_out=0 and halted_out=0 immediately.
